// File: rtl/writeback_stage.sv
// Writeback stage: holds one retiring instruction, aligns/extends load data and drives the
// register-file write port. Optional retire counter built when WB_RETIRE_CNT_EN is defined.
module writeback_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_we,
    input  logic [1:0]            in_wb_sel,
    input  logic [XLEN-1:0]       in_alu,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [2:0]            in_funct3,
    input  logic                  flush,
    input  logic [XLEN-1:0]       dmem_rdata,
    input  logic                  dmem_rvalid,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] wa,
    output logic [XLEN-1:0]       wd,
    output logic [31:0]           retire_cnt,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic                    reg_we_q;
    logic [1:0]              wb_sel_q;
    logic [XLEN-1:0]         alu_q;
    logic [XLEN-1:0]         pc_q;
    logic [2:0]              funct3_q;

    logic                    valid_q;
    logic                    is_load;
    logic                    commit;
    logic                    accept;

    // Handshake: in_* is taken when in_valid && in_ready && !flush. in_ready depends only on
    // the held entry and dmem_rvalid, never on in_valid, so the slot frees in the commit cycle.
    assign valid_q  = (state_q != EMPTY);
    assign is_load  = (wb_sel_q == 2'b01);
    assign commit   = valid_q && (!is_load || dmem_rvalid);
    assign in_ready = !valid_q || commit;
    assign accept   = in_valid && in_ready && !flush;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rd_q     <= '0;
            reg_we_q <= 1'b0;
            wb_sel_q <= 2'b00;
            alu_q    <= '0;
            pc_q     <= '0;
            funct3_q <= 3'b000;
        end else if (accept) begin
            state_q  <= (in_wb_sel == 2'b01) ? WAIT : HOLD;
            rd_q     <= in_rd;
            reg_we_q <= in_reg_we;
            wb_sel_q <= in_wb_sel;
            alu_q    <= in_alu;
            pc_q     <= in_pc;
            funct3_q <= in_funct3;
        end else if (commit) begin
            state_q  <= EMPTY;
        end
    end

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wd_raw;

    // Misaligned LH/LHU use the half selected by off[1] only; LW ignores the offset entirely.
    always_comb begin
        ld_byte = dmem_rdata[{alu_q[1:0], 3'b000} +: 8];
        ld_half = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        case (wb_sel_q)
            2'b01:   wd_raw = ld_data;
            2'b10:   wd_raw = pc_q + XLEN'(4);
            default: wd_raw = alu_q;
        endcase
    end

    assign we = commit && reg_we_q && (rd_q != '0);
    assign wa = rd_q;
    assign wd = (rd_q == '0) ? '0 : wd_raw;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 32'h0;
        end else if (commit) begin
            cnt_q <= cnt_q + 32'h1;
        end
    end

    assign retire_cnt = cnt_q;
`else
    assign retire_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus a randomized stream, all checked against a
// one-entry behavioural model of the stage and a load-alignment reference written arithmetically.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_we;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu;
    logic [31:0] in_pc;
    logic [2:0]  in_funct3;
    logic        flush;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] retire_cnt;
    logic [1:0]  dbg_state;

`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    writeback_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_reg_we(in_reg_we), .in_wb_sel(in_wb_sel), .in_alu(in_alu),
        .in_pc(in_pc), .in_funct3(in_funct3), .flush(flush), .dmem_rdata(dmem_rdata),
        .dmem_rvalid(dmem_rvalid), .we(we), .wa(wa), .wd(wd), .retire_cnt(retire_cnt),
        .dbg_state(dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model of the single held entry
    bit          m_pend;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [31:0] m_alu;
    logic [31:0] m_pc;
    logic [2:0]  m_f3;
    logic [31:0] exp_cnt;
    logic [36:0] exp_q[$];

    logic        obs_we;
    logic        obs_ready;
    logic [4:0]  obs_wa;
    logic [31:0] obs_wd;
    logic [31:0] obs_cnt;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] word,
                                             input logic [31:0] addr);
        logic [31:0] b;
        logic [31:0] h;
        int off;
        off = int'(addr % 4);
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd(input logic [1:0] sel, input logic [31:0] alu,
                                           input logic [31:0] pc, input logic [2:0] f3,
                                           input logic [31:0] word);
        if (sel == 2'b10) return pc + 32'd4;
        if (sel == 2'b01) return ref_load(f3, word, alu);
        return alu;
    endfunction

    // Driver: apply one cycle of inputs, sample mid-cycle, score against the model, advance.
    task automatic drive(input logic v, input logic [4:0] rd, input logic rwe,
                         input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [2:0] f3, input logic fl, input logic [31:0] rdata,
                         input logic rv);
        logic exp_commit;
        logic exp_ready;
        logic exp_we;
        logic [36:0] got;
        logic [36:0] want;
        in_valid = v; in_rd = rd; in_reg_we = rwe; in_wb_sel = sel; in_alu = alu;
        in_pc = pc; in_funct3 = f3; flush = fl; dmem_rdata = rdata; dmem_rvalid = rv;
        #4;
        obs_we = we; obs_ready = in_ready; obs_wa = wa; obs_wd = wd; obs_cnt = retire_cnt;
        exp_commit = m_pend && (m_sel != 2'b01 || rv);
        exp_ready  = !m_pend || exp_commit;
        exp_we     = exp_commit && m_we && (m_rd != 5'd0);
        if (exp_we) exp_q.push_back({m_rd, ref_wd(m_sel, m_alu, m_pc, m_f3, rdata)});
        tests++;
        if (in_ready !== exp_ready) begin
            fails++;
            $display("FAIL model_in_ready t=%0t got %b expected %b", $time, in_ready, exp_ready);
        end
        tests++;
        if (we !== exp_we) begin
            fails++;
            $display("FAIL model_we t=%0t got %b expected %b", $time, we, exp_we);
        end
        if (exp_we) begin
            want = exp_q.pop_front();
            got  = {wa, wd};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL model_wa_wd t=%0t got wa=%0d wd=%h expected wa=%0d wd=%h",
                         $time, got[36:32], got[31:0], want[36:32], want[31:0]);
            end
        end
        tests++;
        if (retire_cnt !== (CNT_EN ? exp_cnt : 32'h0)) begin
            fails++;
            $display("FAIL model_retire_cnt t=%0t got %h expected %h", $time, retire_cnt,
                     CNT_EN ? exp_cnt : 32'h0);
        end
        if (v && exp_ready && !fl) begin
            m_pend = 1'b1; m_we = rwe; m_rd = rd; m_sel = sel; m_alu = alu; m_pc = pc; m_f3 = f3;
        end else if (exp_commit) begin
            m_pend = 1'b0;
        end
        if (exp_commit) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rv, input logic [31:0] rdata);
        drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 3'd0, 1'b0, rdata, rv);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; dmem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_pend = 1'b0;
        exp_cnt = 32'h0;
        exp_q.delete();
        tests++;
        if (we !== 1'b0) begin fails++; $display("FAIL reset_we got %b expected 0", we); end
        tests++;
        if (wa !== 5'd0) begin fails++; $display("FAIL reset_wa got %0d expected 0", wa); end
        tests++;
        if (wd !== 32'h0) begin fails++; $display("FAIL reset_wd got %h expected 0", wd); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        tests++;
        if (retire_cnt !== 32'h0) begin fails++; $display("FAIL reset_retire_cnt got %h expected 0", retire_cnt); end
    endtask

    task automatic test_alu;
        drive(1'b1, 5'd5, 1'b1, 2'b00, 32'h0000_1234, 32'h40, 3'd0, 1'b0, 32'h0, 1'b0);
        idle(1'b0, 32'h0);
        tests++;
        if (obs_we !== 1'b1 || obs_wa !== 5'd5 || obs_wd !== 32'h0000_1234 || obs_ready !== 1'b1) begin
            fails++;
            $display("FAIL alu_write got we=%b wa=%0d wd=%h rdy=%b expected 1/5/00001234/1",
                     obs_we, obs_wa, obs_wd, obs_ready);
        end
    endtask

    task automatic test_load;
        drive(1'b1, 5'd7, 1'b1, 2'b01, 32'h0000_2003, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            idle(1'b0, 32'h80AA_BBCC);
            tests++;
            if (obs_ready !== 1'b0 || obs_we !== 1'b0) begin
                fails++;
                $display("FAIL lb_wait got rdy=%b we=%b expected 0/0", obs_ready, obs_we);
            end
        end
        idle(1'b1, 32'h80AA_BBCC);
        tests++;
        if (obs_we !== 1'b1 || obs_wd !== 32'hFFFF_FF80) begin
            fails++;
            $display("FAIL lb_data got we=%b wd=%h expected 1/ffffff80", obs_we, obs_wd);
        end
        drive(1'b1, 5'd8, 1'b1, 2'b01, 32'h0000_2002, 32'h0, 3'b101, 1'b0, 32'h0, 1'b0);
        idle(1'b1, 32'h80AA_BBCC);
        tests++;
        if (obs_we !== 1'b1 || obs_wd !== 32'h0000_80AA) begin
            fails++;
            $display("FAIL lhu_data got we=%b wd=%h expected 1/000080aa", obs_we, obs_wd);
        end
    endtask

    task automatic test_jal;
        drive(1'b1, 5'd1, 1'b1, 2'b10, 32'hDEAD_0000, 32'h0000_0100, 3'd0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 5'd0, 1'b1, 2'b10, 32'hDEAD_0000, 32'h0000_0200, 3'd0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (obs_we !== 1'b1 || obs_wa !== 5'd1 || obs_wd !== 32'h0000_0104) begin
            fails++;
            $display("FAIL jal_rd1 got we=%b wa=%0d wd=%h expected 1/1/00000104", obs_we, obs_wa, obs_wd);
        end
        idle(1'b0, 32'h0);
        tests++;
        if (obs_we !== 1'b0 || obs_wd !== 32'h0) begin
            fails++;
            $display("FAIL jal_rd0 got we=%b wd=%h expected 0/00000000", obs_we, obs_wd);
        end
    endtask

    task automatic test_flush;
        drive(1'b1, 5'd10, 1'b1, 2'b01, 32'h0000_0000, 32'h0, 3'b010, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 5'd9, 1'b1, 2'b00, 32'h0000_9999, 32'h0, 3'd0, 1'b1, 32'h1357_9BDF, 1'b0);
        drive(1'b1, 5'd9, 1'b1, 2'b00, 32'h0000_9999, 32'h0, 3'd0, 1'b1, 32'h1357_9BDF, 1'b1);
        tests++;
        if (obs_we !== 1'b1 || obs_wa !== 5'd10 || obs_wd !== 32'h1357_9BDF) begin
            fails++;
            $display("FAIL flush_load_commit got we=%b wa=%0d wd=%h expected 1/10/13579bdf",
                     obs_we, obs_wa, obs_wd);
        end
        idle(1'b0, 32'h0);
        tests++;
        if (obs_we !== 1'b0) begin
            fails++;
            $display("FAIL flush_not_accepted got we=%b expected 0", obs_we);
        end
    endtask

    task automatic test_reset_wait;
        drive(1'b1, 5'd12, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010, 1'b0, 32'h0, 1'b0);
        idle(1'b0, 32'h0);
        test_reset;
        idle(1'b1, 32'hCAFE_F00D);
        tests++;
        if (obs_we !== 1'b0 || obs_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_wait_drop got we=%b rdy=%b expected 0/1", obs_we, obs_ready);
        end
    endtask

    task automatic test_back_to_back;
        test_reset;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 5'(i + 2), 1'b1, 2'b00, 32'(100 + i), 32'h0, 3'd0, 1'b0, 32'h0, 1'b0);
        idle(1'b0, 32'h0);
        idle(1'b0, 32'h0);
        tests++;
        if (obs_cnt !== (CNT_EN ? 32'd3 : 32'd0)) begin
            fails++;
            $display("FAIL b2b_retire_cnt got %0d expected %0d", obs_cnt, CNT_EN ? 3 : 0);
        end
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_wrap;
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        drive(1'b1, 5'd3, 1'b1, 2'b00, 32'h1, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0);
        idle(1'b0, 32'h0);
        idle(1'b0, 32'h0);
        tests++;
        if (obs_cnt !== 32'h0) begin
            fails++;
            $display("FAIL cnt_wrap got %h expected 00000000", obs_cnt);
        end
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0, $urandom, 1'($urandom_range(0, 1)));
        end
        idle(1'b1, $urandom);
        idle(1'b1, $urandom);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_reg_we = 1'b0; in_wb_sel = 2'b00;
        in_alu = '0; in_pc = '0; in_funct3 = '0; flush = 1'b0; dmem_rdata = '0; dmem_rvalid = 1'b0;
        m_pend = 1'b0; m_we = 1'b0; m_rd = '0; m_sel = '0; m_alu = '0; m_pc = '0; m_f3 = '0;
        exp_cnt = 32'h0;
        @(posedge clk);
        #1;
        test_reset;
        test_alu;
        test_load;
        test_jal;
        test_flush;
        test_reset_wait;
        test_back_to_back;
`ifdef WB_RETIRE_CNT_EN
        test_wrap;
`endif
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
